issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Single-entry issue controller between decode and the functional units of the in-order pipeline.
- Holds one decoded instruction and interrogates the scoreboard read port for operand and destination hazards.
- Tracks writeback-port reservations in a shift vector and checks per-unit execute readiness.
- Fires the instruction when it is clear, drives the scoreboard's synchronous write port and counts stall cycles.

Parameters:
- LAT_U0, 1, writeback latency of unit 0 in cycles (legal 1..5)
- LAT_U1, 2, writeback latency of unit 1
- LAT_U2, 3, writeback latency of unit 2
- LAT_U3, 5, writeback latency of unit 3
- STALL_W, 16, stall counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  decode offers instruction
- id_ready  out  1  scheduler accepts this cycle
- id_rs_a, id_rs_b  in  5  source registers
- id_use_a, id_use_b  in  1  source actually read
- id_rd  in  5  destination register
- id_writes  in  1  instruction writes id_rd
- id_unit  in  2  target functional unit
- flush  in  1  discard held instruction
- ex_ready  in  4  per-unit accept, bit n = unit n
- sb_addr_a, sb_addr_b, sb_addr_d  out  5  scoreboard query addresses
- sb_pending_a, sb_pending_b, sb_pending_d  in  1  scoreboard pending bits
- sb_row_a, sb_row_b  in  5  scoreboard execution-stage one-hot rows
- iss_valid  out  1  issue pulse
- iss_unit  out  2  unit of issued instruction
- iss_rd  out  5  destination of issued instruction
- sb_write_en  out  1  scoreboard write enable
- sb_write_addr  out  5  register made pending
- sb_write_unit  out  2  unit recorded in scoreboard
- stall_count  out  STALL_W  saturating stall-cycle counter
- stall_clear  in  1  synchronous clear of stall_count

Behaviour:
- Reset (async, reset=1): state EMPTY, held fields 0, wb_busy 0, stall_count 0, iss_valid 0, sb_write_en 0, id_ready 1.
- States:
  - EMPTY: no held instruction.
  - HELD: instruction latched into held registers.
- Transitions:
  - EMPTY → HELD when id_valid & id_ready.
  - HELD → EMPTY on fire with no new accept.
  - HELD → HELD on fire with a new accept (back-to-back, no bubble) or on stall.
  - Any state → EMPTY on flush.
- id_ready = ~flush & (state==EMPTY | fire).
- sb_addr_a/b/d = held rs_a/rs_b/rd, driven combinationally from the held registers.
- LAT = LAT_U[held unit].
- Hazards, evaluated combinationally in HELD:
  - raw_x: use_x & rs_x!=0 & sb_pending_x & ~fwd_ok_x, for x in {a,b}.
  - waw: writes & rd!=0 & sb_pending_d.
  - wb_conf: writes & rd!=0 & wb_busy[LAT].
  - unit_busy: ~ex_ready[unit].
- fire = HELD & ~flush & no hazard.
- iss_valid = fire; iss_unit and iss_rd come from the held registers. Fire is combinational in the same cycle: zero added latency.
- sb_write_en = fire & writes & rd!=0; sb_write_addr = rd; sb_write_unit = unit.
- wb_busy[5:0]: bit k = write port claimed k cycles ahead. Next value = (wb_busy >> 1) | (sb_write_en ? 1<<(LAT-1) : 0). The shift and the new reservation apply in the same edge.
- stall_count:
  - Increments on HELD & ~fire & ~flush.
  - Saturates at all-ones.
  - stall_clear has priority over increment.
- Register 0: never a hazard, never written to the scoreboard, never reserves a writeback slot.
- Flush:
  - Drops the held entry even if it is hazard-free (fire is forced 0).
  - wb_busy keeps shifting; existing reservations are not cancelled.
  - The id offer in the flush cycle is not accepted.
- Reset mid-HELD: the entry is lost and all reservations are cleared.
- id_* inputs are sampled only when id_ready=1.

Optional Feature:
- Macro ISSUE_FWD_EN.
- Defined: fwd_ok_x = (sb_row_x == 5'b00001), i.e. a producer in its final stage is forwarded and does not stall.
- Undefined: fwd_ok_x = 0; any pending source stalls until the scoreboard clears it.

Test Plan:
- Reset with reset=1 mid-HELD → next cycle id_ready=1, iss_valid=0, stall_count=0, wb_busy=0.
- Unit 3 writes r5, then unit 0 reads r5 with sb_pending_a=1 and sb_row_a=5'b00100 → iss_valid=0 and stall_count increments. Fires in the cycle sb_pending_a drops, or, with ISSUE_FWD_EN, when sb_row_a=5'b00001.
- Issue unit 3 (LAT 5) writing r1, then 2 cycles later unit 1 (LAT 2) writing r2 → wb_busy[2] set, so the unit 1 instruction stalls 1 cycle, then fires with sb_write_addr=2, sb_write_unit=1.
- Back-to-back hazard-free ops on unit 0 with ex_ready=4'b1111 → iss_valid high on consecutive cycles, id_ready stays 1.
- Held instruction plus flush=1 with id_valid=1 in the same cycle → iss_valid=0, id_ready=0, state EMPTY next cycle.
- rd=0, writes=1, fire → sb_write_en=0 and no wb_busy bit set; after 2^STALL_W+3 stall cycles stall_count=all-ones; stall_clear → 0.

Source files
------------

// File: rtl/issue_scheduler.sv
// Single-entry issue controller: holds one decoded instruction, checks scoreboard,
// writeback-port and unit hazards, and fires it. Optional forwarding: ISSUE_FWD_EN.
module issue_scheduler #(
    parameter int unsigned LAT_U0  = 1,
    parameter int unsigned LAT_U1  = 2,
    parameter int unsigned LAT_U2  = 3,
    parameter int unsigned LAT_U3  = 5,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [4:0]         id_rs_a,
    input  logic [4:0]         id_rs_b,
    input  logic               id_use_a,
    input  logic               id_use_b,
    input  logic [4:0]         id_rd,
    input  logic               id_writes,
    input  logic [1:0]         id_unit,
    input  logic               flush,
    input  logic [3:0]         ex_ready,
    output logic [4:0]         sb_addr_a,
    output logic [4:0]         sb_addr_b,
    output logic [4:0]         sb_addr_d,
    input  logic               sb_pending_a,
    input  logic               sb_pending_b,
    input  logic               sb_pending_d,
    input  logic [4:0]         sb_row_a,
    input  logic [4:0]         sb_row_b,
    output logic               iss_valid,
    output logic [1:0]         iss_unit,
    output logic [4:0]         iss_rd,
    output logic               sb_write_en,
    output logic [4:0]         sb_write_addr,
    output logic [1:0]         sb_write_unit,
    output logic [STALL_W-1:0] stall_count,
    input  logic               stall_clear
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t     state;
    logic [4:0] h_rs_a, h_rs_b, h_rd;
    logic       h_use_a, h_use_b, h_writes;
    logic [1:0] h_unit;
    logic [5:0] wb_busy;
    logic [5:0] wb_new;
    logic [2:0] lat;
    logic       fwd_ok_a, fwd_ok_b;
    logic       wr_real;
    logic       raw_a, raw_b, waw, wb_conf, unit_busy;
    logic       held, fire, accept;

`ifdef ISSUE_FWD_EN
    // A producer in its last execute stage is forwarded, so it does not stall.
    assign fwd_ok_a = (sb_row_a == 5'b00001);
    assign fwd_ok_b = (sb_row_b == 5'b00001);
`else
    logic unused_rows;
    assign unused_rows = ^{sb_row_a, sb_row_b};
    assign fwd_ok_a    = 1'b0;
    assign fwd_ok_b    = 1'b0;
`endif

    always_comb begin
        lat = 3'(LAT_U0);
        case (h_unit)
            2'd0: lat = 3'(LAT_U0);
            2'd1: lat = 3'(LAT_U1);
            2'd2: lat = 3'(LAT_U2);
            2'd3: lat = 3'(LAT_U3);
        endcase
    end

    assign held      = (state == HELD);
    assign wr_real   = h_writes & (h_rd != '0);
    assign raw_a     = h_use_a & (h_rs_a != '0) & sb_pending_a & ~fwd_ok_a;
    assign raw_b     = h_use_b & (h_rs_b != '0) & sb_pending_b & ~fwd_ok_b;
    assign waw       = wr_real & sb_pending_d;
    assign wb_conf   = wr_real & wb_busy[lat];
    assign unit_busy = ~ex_ready[h_unit];

    assign fire     = held & ~flush & ~(raw_a | raw_b | waw | wb_conf | unit_busy);
    assign id_ready = ~flush & (~held | fire);
    assign accept   = id_valid & id_ready;

    assign sb_addr_a     = h_rs_a;
    assign sb_addr_b     = h_rs_b;
    assign sb_addr_d     = h_rd;
    assign iss_valid     = fire;
    assign iss_unit      = h_unit;
    assign iss_rd        = h_rd;
    assign sb_write_en   = fire & wr_real;
    assign sb_write_addr = h_rd;
    assign sb_write_unit = h_unit;

    // Reservation lands at LAT-1 because the whole vector shifts on the same edge.
    assign wb_new = sb_write_en ? (6'd1 << (lat - 3'd1)) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            h_rs_a   <= '0;
            h_rs_b   <= '0;
            h_rd     <= '0;
            h_use_a  <= 1'b0;
            h_use_b  <= 1'b0;
            h_writes <= 1'b0;
            h_unit   <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state    <= HELD;
            h_rs_a   <= id_rs_a;
            h_rs_b   <= id_rs_b;
            h_rd     <= id_rd;
            h_use_a  <= id_use_a;
            h_use_b  <= id_use_b;
            h_writes <= id_writes;
            h_unit   <= id_unit;
        end else if (fire) begin
            state <= EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_busy <= '0;
        end else begin
            wb_busy <= (wb_busy >> 1) | wb_new;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_clear) begin
            stall_count <= '0;
        end else if (held & ~fire & ~flush & ~(&stall_count)) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus a randomized run
// against an absolute-time reference model of hazards and writeback reservations.
`timescale 1ns/1ps
module tb_issue_scheduler;

    localparam int unsigned SW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid, id_ready;
    logic [4:0]    id_rs_a, id_rs_b, id_rd;
    logic          id_use_a, id_use_b, id_writes;
    logic [1:0]    id_unit;
    logic          flush;
    logic [3:0]    ex_ready;
    logic [4:0]    sb_addr_a, sb_addr_b, sb_addr_d;
    logic          sb_pending_a, sb_pending_b, sb_pending_d;
    logic [4:0]    sb_row_a, sb_row_b;
    logic          iss_valid;
    logic [1:0]    iss_unit;
    logic [4:0]    iss_rd;
    logic          sb_write_en;
    logic [4:0]    sb_write_addr;
    logic [1:0]    sb_write_unit;
    logic [SW-1:0] stall_count;
    logic          stall_clear;

    always #5 clock = ~clock;

    issue_scheduler #(
        .LAT_U0(1), .LAT_U1(2), .LAT_U2(3), .LAT_U3(5), .STALL_W(SW)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_rd(id_rd), .id_writes(id_writes), .id_unit(id_unit),
        .flush(flush), .ex_ready(ex_ready),
        .sb_addr_a(sb_addr_a), .sb_addr_b(sb_addr_b), .sb_addr_d(sb_addr_d),
        .sb_pending_a(sb_pending_a), .sb_pending_b(sb_pending_b), .sb_pending_d(sb_pending_d),
        .sb_row_a(sb_row_a), .sb_row_b(sb_row_b),
        .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_rd(iss_rd),
        .sb_write_en(sb_write_en), .sb_write_addr(sb_write_addr), .sb_write_unit(sb_write_unit),
        .stall_count(stall_count), .stall_clear(stall_clear)
    );

    // Reference model: reservations are kept as absolute writeback cycle numbers.
    typedef struct packed {
        logic [4:0] rs_a;
        logic [4:0] rs_b;
        logic [4:0] rd;
        logic       use_a;
        logic       use_b;
        logic       writes;
        logic [1:0] unit;
    } ins_t;

    int    lat_tab [4] = '{1, 2, 3, 5};
    bit    m_held;
    ins_t  m_ins;
    int    m_cyc = 0;
    bit    m_busy [int];
    int    m_stall;
    bit    e_fire, e_ready, e_wen;
    int    checks = 0;
    int    errors = 0;

    function automatic bit fwd(input logic [4:0] row);
`ifdef ISSUE_FWD_EN
        return row == 5'b00001;
`else
        return row == 5'b11111 && 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_held  = 1'b0;
        m_ins   = '0;
        m_stall = 0;
        m_busy.delete();
    endfunction

    function automatic void model_eval();
        int l;
        bit wr, hz;
        l  = lat_tab[m_ins.unit];
        wr = m_ins.writes && (m_ins.rd != 5'd0);
        hz = (m_ins.use_a && m_ins.rs_a != 5'd0 && sb_pending_a && !fwd(sb_row_a))
          || (m_ins.use_b && m_ins.rs_b != 5'd0 && sb_pending_b && !fwd(sb_row_b))
          || (wr && sb_pending_d)
          || (wr && m_busy.exists(m_cyc + l))
          || !ex_ready[m_ins.unit];
        e_fire  = m_held && !flush && !hz;
        e_ready = !flush && (!m_held || e_fire);
        e_wen   = e_fire && wr;
    endfunction

    function automatic void model_update();
        m_cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        if (e_wen) m_busy[m_cyc - 1 + lat_tab[m_ins.unit]] = 1'b1;
        if (stall_clear) m_stall = 0;
        else if (m_held && !e_fire && !flush && m_stall < (1 << SW) - 1) m_stall++;
        if (flush) m_held = 1'b0;
        else if (id_valid && e_ready) begin
            m_held       = 1'b1;
            m_ins.rs_a   = id_rs_a;
            m_ins.rs_b   = id_rs_b;
            m_ins.rd     = id_rd;
            m_ins.use_a  = id_use_a;
            m_ins.use_b  = id_use_b;
            m_ins.writes = id_writes;
            m_ins.unit   = id_unit;
        end else if (e_fire) m_held = 1'b0;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    function automatic void idle_inputs();
        reset = 1'b0; id_valid = 1'b0; id_rs_a = '0; id_rs_b = '0; id_rd = '0;
        id_use_a = 1'b0; id_use_b = 1'b0; id_writes = 1'b0; id_unit = '0;
        flush = 1'b0; ex_ready = 4'hF; sb_pending_a = 1'b0; sb_pending_b = 1'b0;
        sb_pending_d = 1'b0; sb_row_a = '0; sb_row_b = '0; stall_clear = 1'b0;
    endfunction

    function automatic void offer(input logic [1:0] u, input logic [4:0] rsa, input logic ua,
                                  input logic [4:0] rsb, input logic ub,
                                  input logic [4:0] rd, input logic wr);
        id_valid = 1'b1; id_unit = u; id_rs_a = rsa; id_use_a = ua;
        id_rs_b = rsb; id_use_b = ub; id_rd = rd; id_writes = wr;
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
        checks++; if (sb_write_en !== 1'b0) begin errors++; $display("FAIL reset_sb_write_en got %b want 0", sb_write_en); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        checks++; if ({sb_addr_a, sb_addr_b, sb_addr_d} !== 15'd0) begin errors++;
            $display("FAIL reset_sb_addr got %h want 0", {sb_addr_a, sb_addr_b, sb_addr_d}); end
    endtask

    task automatic test_raw_stall();
        bit exp_fwd_fire;
`ifdef ISSUE_FWD_EN
        exp_fwd_fire = 1'b1;
`else
        exp_fwd_fire = 1'b0;
`endif
        idle_inputs(); repeat (6) tick();
        stall_clear = 1'b1; offer(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_accept got %b want 1", id_ready); end
        tick();
        stall_clear = 1'b0; offer(2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0); #1;
        checks++; if ({iss_valid, sb_write_en, sb_write_addr, sb_write_unit} !== {1'b1, 1'b1, 5'd5, 2'd3}) begin errors++;
            $display("FAIL raw_producer_issue got %b want %b", {iss_valid, sb_write_en, sb_write_addr, sb_write_unit}, {1'b1, 1'b1, 5'd5, 2'd3}); end
        tick();
        idle_inputs(); sb_pending_a = 1'b1; sb_row_a = 5'b00100; #1;
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %b want 0", iss_valid); end
        checks++; if (sb_addr_a !== 5'd5) begin errors++; $display("FAIL raw_sb_addr_a got %0d want 5", sb_addr_a); end
        tick(); #1;
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL raw_stall2 got %b want 0", iss_valid); end
        checks++; if (stall_count !== SW'(1)) begin errors++; $display("FAIL raw_stall_count got %0d want 1", stall_count); end
        tick();
        sb_row_a = 5'b00001; #1;
        checks++; if (iss_valid !== exp_fwd_fire) begin errors++; $display("FAIL raw_final_stage got %b want %b", iss_valid, exp_fwd_fire); end
        tick();
        sb_pending_a = 1'b0; sb_row_a = '0; #1;
        checks++; if (iss_valid !== !exp_fwd_fire) begin errors++; $display("FAIL raw_release got %b want %b", iss_valid, !exp_fwd_fire); end
        checks++; if (stall_count !== (exp_fwd_fire ? SW'(2) : SW'(3))) begin errors++;
            $display("FAIL raw_total_stall got %0d want %0d", stall_count, exp_fwd_fire ? 2 : 3); end
        tick();
    endtask

    task automatic test_wb_conflict();
        idle_inputs(); repeat (6) tick();
        offer(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1); tick();
        idle_inputs(); #1;
        checks++; if (sb_write_en !== 1'b1) begin errors++; $display("FAIL wb_first_write got %b want 1", sb_write_en); end
        tick();
        tick();
        offer(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1); tick();
        idle_inputs(); #1;
        checks++; if ({iss_valid, sb_write_en} !== 2'b00) begin errors++; $display("FAIL wb_conflict_stall got %b want 00", {iss_valid, sb_write_en}); end
        tick(); #1;
        checks++; if ({iss_valid, sb_write_en, sb_write_addr, sb_write_unit} !== {1'b1, 1'b1, 5'd2, 2'd1}) begin errors++;
            $display("FAIL wb_conflict_fire got %b want %b", {iss_valid, sb_write_en, sb_write_addr, sb_write_unit}, {1'b1, 1'b1, 5'd2, 2'd1}); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs(); repeat (6) tick();
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) offer(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'(k + 1), 1'b1);
            else idle_inputs();
            #1;
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_id_ready k=%0d got %b want 1", k, id_ready); end
            if (k > 0) begin
                checks++; if ({iss_valid, iss_rd} !== {1'b1, 5'(k)}) begin errors++;
                    $display("FAIL b2b_issue k=%0d got v=%b rd=%0d want v=1 rd=%0d", k, iss_valid, iss_rd, k); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        idle_inputs(); repeat (6) tick();
        offer(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); tick();
        flush = 1'b1; offer(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1); #1;
        checks++; if ({iss_valid, id_ready, sb_write_en} !== 3'b000) begin errors++;
            $display("FAIL flush_cycle got %b want 000", {iss_valid, id_ready, sb_write_en}); end
        tick();
        idle_inputs(); #1;
        checks++; if ({iss_valid, id_ready} !== 2'b01) begin errors++; $display("FAIL flush_empty got %b want 01", {iss_valid, id_ready}); end
        tick();
    endtask

    task automatic test_r0_and_saturation();
        idle_inputs(); repeat (6) tick();
        offer(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); tick();
        offer(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1); #1;
        checks++; if ({iss_valid, sb_write_en, iss_rd} !== {1'b1, 1'b0, 5'd0}) begin errors++;
            $display("FAIL r0_issue got %b want %b", {iss_valid, sb_write_en, iss_rd}, {1'b1, 1'b0, 5'd0}); end
        tick();
        idle_inputs(); #1;
        checks++; if ({iss_valid, sb_write_en} !== 2'b11) begin errors++; $display("FAIL r0_no_reservation got %b want 11", {iss_valid, sb_write_en}); end
        tick();
        stall_clear = 1'b1; offer(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); tick();
        idle_inputs(); ex_ready = 4'b1011;
        repeat ((1 << SW) + 3) tick();
        #1;
        checks++; if (stall_count !== '1) begin errors++; $display("FAIL stall_saturate got %0d want %0d", stall_count, (1 << SW) - 1); end
        stall_clear = 1'b1; tick();
        stall_clear = 1'b0; #1;
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL stall_clear got %0d want 0", stall_count); end
        ex_ready = 4'hF; #1;
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL sat_release got %b want 1", iss_valid); end
        tick();
    endtask

    task automatic test_reset_mid_held();
        idle_inputs(); repeat (6) tick();
        stall_clear = 1'b1; offer(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); tick();
        stall_clear = 1'b0; offer(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1); tick();
        idle_inputs(); ex_ready = 4'b1011; tick();
        #1;
        checks++; if (stall_count !== SW'(1)) begin errors++; $display("FAIL rst_pre_stall got %0d want 1", stall_count); end
        reset = 1'b1; #1;
        checks++; if ({id_ready, iss_valid} !== 2'b10) begin errors++; $display("FAIL rst_mid_ready_valid got %b want 10", {id_ready, iss_valid}); end
        checks++; if (stall_count !== '0) begin errors++; $display("FAIL rst_mid_stall got %0d want 0", stall_count); end
        tick();
        reset = 1'b0; ex_ready = 4'hF; offer(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); tick();
        idle_inputs(); #1;
        checks++; if ({iss_valid, sb_write_en} !== 2'b11) begin errors++; $display("FAIL rst_cleared_wb got %b want 11", {iss_valid, sb_write_en}); end
        tick();
    endtask

    task automatic test_random();
        idle_inputs(); repeat (6) tick();
        for (int k = 0; k < 600; k++) begin
            id_valid     = ($urandom_range(9) < 7);
            id_unit      = 2'($urandom_range(3));
            id_rs_a      = 5'($urandom_range(4));
            id_rs_b      = 5'($urandom_range(4));
            id_rd        = 5'($urandom_range(4));
            id_use_a     = 1'($urandom_range(1));
            id_use_b     = 1'($urandom_range(1));
            id_writes    = 1'($urandom_range(1));
            flush        = ($urandom_range(19) == 0);
            ex_ready     = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            sb_pending_a = ($urandom_range(3) == 0);
            sb_pending_b = ($urandom_range(3) == 0);
            sb_pending_d = ($urandom_range(5) == 0);
            sb_row_a     = 5'(1 << $urandom_range(4));
            sb_row_b     = 5'(1 << $urandom_range(4));
            stall_clear  = ($urandom_range(29) == 0);
            #1;
            model_eval();
            checks++; if ({id_ready, iss_valid, sb_write_en} !== {e_ready, e_fire, e_wen}) begin errors++;
                $display("FAIL rnd_ctrl k=%0d got %b want %b", k, {id_ready, iss_valid, sb_write_en}, {e_ready, e_fire, e_wen}); end
            checks++; if ({iss_unit, iss_rd, sb_write_addr, sb_write_unit, sb_addr_a, sb_addr_b, sb_addr_d}
                          !== {m_ins.unit, m_ins.rd, m_ins.rd, m_ins.unit, m_ins.rs_a, m_ins.rs_b, m_ins.rd}) begin errors++;
                $display("FAIL rnd_fields k=%0d got %h want %h", k,
                         {iss_unit, iss_rd, sb_write_addr, sb_write_unit, sb_addr_a, sb_addr_b, sb_addr_d},
                         {m_ins.unit, m_ins.rd, m_ins.rd, m_ins.unit, m_ins.rs_a, m_ins.rs_b, m_ins.rd}); end
            checks++; if (stall_count !== SW'(m_stall)) begin errors++;
                $display("FAIL rnd_stall k=%0d got %0d want %0d", k, stall_count, m_stall); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_raw_stall();
        test_wb_conflict();
        test_back_to_back();
        test_flush();
        test_r0_and_saturation();
        test_reset_mid_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
